// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads each 16-bit instruction as two byte
// reads (high byte first) and hands it to the decoder over valid/ready.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH_HI,
    S_FETCH_LO,
    S_VALID
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]           instr_q, instr_d;
  logic                  xfer;

  assign mem_req     = (state_q == S_FETCH_HI) ||
                       (state_q == S_FETCH_LO);
  assign mem_addr    = (state_q == S_FETCH_LO) ?
                       pc_q + ADDR_WIDTH'(1) : pc_q;
  assign instr_valid = (state_q == S_VALID);
  assign xfer        = instr_valid & instr_ready;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

  // Next-state: redirect wins over any byte returning this cycle; a
  // redirect alongside a transfer still lets the decoder take instr.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = fetch_en ? S_FETCH_HI : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fetch_en) state_d = S_FETCH_HI;
        end
        S_FETCH_HI: begin
          if (mem_ready) begin
            instr_d[15:8] = mem_rdata;
            state_d       = S_FETCH_LO;
          end
        end
        S_FETCH_LO: begin
          if (mem_ready) begin
            instr_d[7:0] = mem_rdata;
            instr_pc_d   = pc_q;
            pc_d         = pc_q + ADDR_WIDTH'(2);
            state_d      = S_VALID;
          end
        end
        S_VALID: begin
          if (xfer) state_d = fetch_en ? S_FETCH_HI : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic,
// with a scoreboard checking every accepted instruction.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  pc;

  instr_fetch_unit #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc)
  );

  always #5 clk = ~clk;

  // memory model: mode 0 zero-wait, 1 random, 2 three-cycle wait
  logic [7:0] mem [256];
  int         mode = 0;
  logic       rnd_rdy = 1'b0;
  int         wcnt = 0;

  assign mem_ready = mem_req && ((mode == 0) ? 1'b1 :
                                 (mode == 1) ? rnd_rdy :
                                 (wcnt == 2));
  assign mem_rdata = mem_ready ? mem[mem_addr] : 8'hEE;

  always @(posedge clk)
    wcnt <= (!rst_n || redirect || !mem_req || mem_ready) ? 0 : wcnt + 1;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  int n_xfer = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // scoreboard events: PC reloads (reset or redirect) at a given edge
  typedef struct packed {
    int unsigned e;
    logic [7:0]  pc;
  } ev_t;
  ev_t ev_q[$];

  task automatic step();
    if (!rst_n) ev_q.push_back('{e: cyc, pc: 8'h00});
    else if (redirect) ev_q.push_back('{e: cyc, pc: redirect_pc});
    @(posedge clk);
    #1;
  endtask

  // monitor: reference model is "instructions are consecutive byte
  // pairs from the last reload point, stepping by two"
  logic [7:0]  model_pc = 8'h00;
  bit          hold_q = 0;
  logic [15:0] prev_instr;
  logic [7:0]  prev_ipc;

  always @(negedge clk) begin
    logic [7:0] p1;
    while (ev_q.size() > 0 && ev_q[0].e < cyc) begin
      model_pc = ev_q[0].pc;
      void'(ev_q.pop_front());
    end
    if (started) begin
      if (hold_q) begin
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", {16'd0, instr}, {16'd0, prev_instr});
        chk("hold_ipc", {24'd0, instr_pc}, {24'd0, prev_ipc});
      end
      if (rst_n) chk("req_valid_excl", {31'd0, mem_req & instr_valid}, 0);
      if (rst_n && instr_valid && instr_ready) begin
        p1 = model_pc + 8'd1;
        chk("xfer_instr", {16'd0, instr},
            {16'd0, mem[model_pc], mem[p1]});
        chk("xfer_ipc", {24'd0, instr_pc}, {24'd0, model_pc});
        model_pc = model_pc + 8'd2;
        n_xfer++;
      end
    end
    hold_q = started && rst_n && instr_valid && !instr_ready && !redirect;
    prev_instr = instr;
    prev_ipc = instr_pc;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h1A;
    mem[8'h01] = 8'h2B;
    rst_n = 0; fetch_en = 0; redirect = 0;
    redirect_pc = 0; instr_ready = 0;
    step(); step();
    started = 1;
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_pc", {24'd0, pc}, 0);
    chk("rst_instr", {16'd0, instr}, 0);
    chk("rst_ipc", {24'd0, instr_pc}, 0);
    chk("rst_addr", {24'd0, mem_addr}, 0);

    // zero-wait fetch after reset release
    rst_n = 1; fetch_en = 1;
    step();
    chk("zw_hi_req", {31'd0, mem_req}, 1);
    chk("zw_hi_addr", {24'd0, mem_addr}, 32'h00);
    step();
    chk("zw_lo_addr", {24'd0, mem_addr}, 32'h01);
    step();
    chk("zw_valid", {31'd0, instr_valid}, 1);
    chk("zw_instr", {16'd0, instr}, 32'h1A2B);
    chk("zw_ipc", {24'd0, instr_pc}, 32'h00);
    chk("zw_pc", {24'd0, pc}, 32'h02);

    // backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req", {31'd0, mem_req}, 0);
      chk("bp_instr", {16'd0, instr}, 32'h1A2B);
    end
    instr_ready = 1;
    step();
    chk("bp_next_addr", {24'd0, mem_addr}, 32'h02);
    chk("bp_next_req", {31'd0, mem_req}, 1);

    // three-cycle wait memory, restart at 00 via redirect
    mode = 2; redirect = 1; redirect_pc = 8'h00; instr_ready = 0;
    step();
    redirect = 0;
    for (int i = 0; i < 3; i++) begin
      chk("w_hi_addr", {24'd0, mem_addr}, 32'h00);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("w_lo_addr", {24'd0, mem_addr}, 32'h01);
      chk("w_lo_valid", {31'd0, instr_valid}, 0);
      step();
    end
    chk("w_valid", {31'd0, instr_valid}, 1);
    chk("w_instr", {16'd0, instr}, 32'h1A2B);
    instr_ready = 1; fetch_en = 0;
    step();
    chk("w_idle_req", {31'd0, mem_req}, 0);

    // redirect during FETCH_LO with mem_ready
    mode = 0; fetch_en = 1;
    step(); step();
    redirect = 1; redirect_pc = 8'h40;
    step();
    redirect = 0;
    chk("rd_valid", {31'd0, instr_valid}, 0);
    chk("rd_addr", {24'd0, mem_addr}, 32'h40);
    chk("rd_pc", {24'd0, pc}, 32'h40);
    step(); step();
    chk("rd_instr", {16'd0, instr}, {16'd0, mem[8'h40], mem[8'h41]});
    chk("rd_ipc", {24'd0, instr_pc}, 32'h40);
    step();

    // wrap from FF
    mem[8'hFF] = 8'hC3;
    mem[8'h00] = 8'h05;
    instr_ready = 0; redirect = 1; redirect_pc = 8'hFF;
    step();
    redirect = 0;
    chk("wr_hi_addr", {24'd0, mem_addr}, 32'hFF);
    step();
    chk("wr_lo_addr", {24'd0, mem_addr}, 32'h00);
    step();
    chk("wr_instr", {16'd0, instr}, 32'hC305);
    chk("wr_ipc", {24'd0, instr_pc}, 32'hFF);
    chk("wr_pc", {24'd0, pc}, 32'h01);
    instr_ready = 1;
    step();

    // wrap from FE
    redirect = 1; redirect_pc = 8'hFE; instr_ready = 0;
    step();
    redirect = 0;
    step(); step();
    chk("fe_ipc", {24'd0, instr_pc}, 32'hFE);
    chk("fe_pc", {24'd0, pc}, 32'h00);
    instr_ready = 1;
    step();

    // reset while FETCH_HI waits
    mode = 2; redirect = 1; redirect_pc = 8'h10;
    step();
    redirect = 0;
    step();
    chk("mr_wait_req", {31'd0, mem_req}, 1);
    rst_n = 0;
    step();
    chk("mr_req", {31'd0, mem_req}, 0);
    chk("mr_valid", {31'd0, instr_valid}, 0);
    chk("mr_pc", {24'd0, pc}, 32'h00);

    // random traffic
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mode = 1;
    step();
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom % 200) != 0;
      fetch_en    = ($urandom % 5) != 0;
      instr_ready = ($urandom % 5) < 3;
      redirect    = ($urandom % 20) == 0;
      redirect_pc = 8'($urandom);
      rnd_rdy     = ($urandom % 3) != 0;
      step();
    end
    rst_n = 1; redirect = 0; fetch_en = 0; instr_ready = 1; rnd_rdy = 1;
    for (int i = 0; i < 8; i++) step();
    chk("xfer_count", {31'd0, n_xfer > 200}, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
